// File: rtl/piso_stream.sv
// rtl/piso_stream.sv - parallel-in serial-out word transmitter with sclk/cs_n framing.
// Optional serial capture path (sdi_in -> data_out) enabled by macro PISO_STREAM_SDI_EN.
module piso_stream #(
  parameter int SIZE      = 8,
  parameter int DIV       = 2,
  parameter int LSB_FIRST = 0
) (
  input  logic            clk_in,
  input  logic            reset_in,
  input  logic [SIZE-1:0] data_in,
  input  logic            valid_in,
  output logic            ready_out,
  output logic            r_out,
  output logic            sclk_out,
  output logic            cs_n_out,
`ifdef PISO_STREAM_SDI_EN
  input  logic            sdi_in,
  output logic [SIZE-1:0] data_out,
`endif
  output logic            done_out
);

  localparam int DW = $clog2(DIV + 1);
  localparam int BW = $clog2(SIZE + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(SIZE - 1);
  localparam logic [BW-1:0] BIT_END  = BW'(SIZE);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t          r_state, w_state;
  logic [DW-1:0]   r_div_cnt, w_div_cnt;
  logic [BW-1:0]   r_bit_cnt, w_bit_cnt;
  logic [SIZE-1:0] r_shreg, w_shreg;
  logic            r_sdo, w_sdo;
  logic            r_sclk, w_sclk;
  logic            r_cs_n, w_cs_n;
  logic            r_done, w_done;
  logic            w_div_last;

  assign w_div_last = (r_div_cnt == DIV_LAST);

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_state   <= IDLE;
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
      r_shreg   <= '0;
      r_sdo     <= 1'b0;
      r_sclk    <= 1'b0;
      r_cs_n    <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_div_cnt <= w_div_cnt;
      r_bit_cnt <= w_bit_cnt;
      r_shreg   <= w_shreg;
      r_sdo     <= w_sdo;
      r_sclk    <= w_sclk;
      r_cs_n    <= w_cs_n;
      r_done    <= w_done;
    end
  end

  always_comb begin
    w_state   = r_state;
    w_div_cnt = r_div_cnt;
    w_bit_cnt = r_bit_cnt;
    w_shreg   = r_shreg;
    w_sdo     = r_sdo;
    w_sclk    = r_sclk;
    w_cs_n    = r_cs_n;
    w_done    = 1'b0;
    case (r_state)
      IDLE: begin
        if (valid_in) begin
          w_state   = SETUP;
          w_shreg   = data_in;
          w_sdo     = (LSB_FIRST != 0) ? data_in[0] : data_in[SIZE-1];
          w_cs_n    = 1'b0;
          w_sclk    = 1'b0;
          w_div_cnt = '0;
          w_bit_cnt = '0;
        end
      end
      SETUP: begin
        if (w_div_last) begin
          w_state   = SHIFT;
          w_div_cnt = '0;
          w_sclk    = 1'b1;
        end else begin
          w_div_cnt = r_div_cnt + 1'b1;
        end
      end
      SHIFT: begin
        if (!w_div_last) begin
          w_div_cnt = r_div_cnt + 1'b1;
        end else begin
          w_div_cnt = '0;
          if (r_sclk) begin
            // Falling edge: advance data, except after the last bit so r_out holds through HOLD.
            w_sclk    = 1'b0;
            w_bit_cnt = r_bit_cnt + 1'b1;
            if (r_bit_cnt != BIT_LAST) begin
              if (LSB_FIRST != 0) begin
                w_shreg = r_shreg >> 1;
                w_sdo   = r_shreg[1];
              end else begin
                w_shreg = r_shreg << 1;
                w_sdo   = r_shreg[SIZE-2];
              end
            end
          end else if (r_bit_cnt == BIT_END) begin
            w_state = HOLD;
          end else begin
            w_sclk = 1'b1;
          end
        end
      end
      HOLD: begin
        if (w_div_last) begin
          w_state   = IDLE;
          w_cs_n    = 1'b1;
          w_done    = 1'b1;
          w_div_cnt = '0;
          w_bit_cnt = '0;
        end else begin
          w_div_cnt = r_div_cnt + 1'b1;
        end
      end
      default: w_state = IDLE;
    endcase
  end

  assign ready_out = (r_state == IDLE);
  assign r_out     = r_sdo;
  assign sclk_out  = r_sclk;
  assign cs_n_out  = r_cs_n;
  assign done_out  = r_done;

`ifdef PISO_STREAM_SDI_EN
  logic [SIZE-1:0] r_cap;
  logic [SIZE-1:0] r_data;

  // sdi_in is sampled on the edge that raises sclk, mirroring the transmit bit order.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_cap  <= '0;
      r_data <= '0;
    end else begin
      if (w_sclk && !r_sclk) begin
        r_cap <= (LSB_FIRST != 0) ? {sdi_in, r_cap[SIZE-1:1]} : {r_cap[SIZE-2:0], sdi_in};
      end
      if (w_done) begin
        r_data <= r_cap;
      end
    end
  end

  assign data_out = r_data;
`endif

endmodule

// File: tb/tb_piso_stream.sv
// tb/tb_piso_stream.sv - table-driven bench for piso_stream (MSB- and LSB-first instances).
module tb_piso_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic       valid;

  logic rdy_m, r_m, sclk_m, cs_m, done_m;
  logic rdy_l, r_l, sclk_l, cs_l, done_l;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  piso_stream #(.SIZE(8), .DIV(2), .LSB_FIRST(0)) u_msb (
    .clk_in(clk), .reset_in(rst), .data_in(data), .valid_in(valid),
    .ready_out(rdy_m), .r_out(r_m), .sclk_out(sclk_m), .cs_n_out(cs_m),
`ifdef PISO_STREAM_SDI_EN
    .sdi_in(r_m), .data_out(),
`endif
    .done_out(done_m)
  );

  piso_stream #(.SIZE(8), .DIV(2), .LSB_FIRST(1)) u_lsb (
    .clk_in(clk), .reset_in(rst), .data_in(data), .valid_in(valid),
    .ready_out(rdy_l), .r_out(r_l), .sclk_out(sclk_l), .cs_n_out(cs_l),
`ifdef PISO_STREAM_SDI_EN
    .sdi_in(r_l), .data_out(),
`endif
    .done_out(done_l)
  );

`ifdef PISO_STREAM_SDI_EN
  logic       rdy_s, r_s, sclk_s, cs_s, done_s;
  logic [7:0] dout_s;
  logic [7:0] last_sdi = 8'h00;

  piso_stream #(.SIZE(8), .DIV(1), .LSB_FIRST(0)) u_sdi (
    .clk_in(clk), .reset_in(rst), .data_in(data), .valid_in(valid),
    .ready_out(rdy_s), .r_out(r_s), .sclk_out(sclk_s), .cs_n_out(cs_s),
    .sdi_in(r_s), .data_out(dout_s),
    .done_out(done_s)
  );

  always @(negedge clk) if (done_s) last_sdi <= dout_s;
`endif

  // Monitor: captures r_out at every sclk rise and counts frame timing.
  logic [7:0] cap_m = 8'h00, cap_l = 8'h00;
  logic       prev_m = 1'b0, prev_l = 1'b0;
  int rise_m = 0, cslow_m = 0, dcnt_m = 0, dcnt_l = 0, hi_run = 0, last_gap = 0;

  always @(negedge clk) begin
    if (sclk_m && !prev_m) begin
      cap_m  <= {cap_m[6:0], r_m};
      rise_m <= rise_m + 1;
    end
    if (sclk_l && !prev_l) cap_l <= {cap_l[6:0], r_l};
    prev_m <= sclk_m;
    prev_l <= sclk_l;
    if (!cs_m) cslow_m <= cslow_m + 1;
    if (done_m) dcnt_m <= dcnt_m + 1;
    if (done_l) dcnt_l <= dcnt_l + 1;
    if (cs_m) hi_run <= hi_run + 1;
    else begin
      if (hi_run != 0) last_gap <= hi_run;
      hi_run <= 0;
    end
  end

  typedef struct {
    logic [7:0] din;
    logic [7:0] exp_m;
    logic [7:0] exp_l;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  task automatic start_word(input logic [7:0] d);
    @(posedge clk); #1;
    data  = d;
    valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int  n   = 0;
    bit  got = 1'b0;
    while (!got && n < 300) begin
      @(negedge clk);
      if (done_m) got = 1'b1;
      n++;
    end
    check({name, " done seen"}, 32'(got), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int s_rise, s_cs, s_dm, s_dl;

    vecs[0] = '{8'hAC, 8'hAC, 8'h35};
    vecs[1] = '{8'h53, 8'h53, 8'hCA};
    vecs[2] = '{8'hFF, 8'hFF, 8'hFF};
    vecs[3] = '{8'h00, 8'h00, 8'h00};
    vecs[4] = '{8'h01, 8'h01, 8'h80};
    vecs[5] = '{8'h80, 8'h80, 8'h01};

    rst   = 1'b1;
    valid = 1'b0;
    data  = 8'h00;
    #1;
    check("reset ready", 32'(rdy_m), 32'd1);
    check("reset cs_n", 32'(cs_m), 32'd1);
    check("reset sclk", 32'(sclk_m), 32'd0);
    check("reset r_out", 32'(r_m), 32'd0);
    check("reset done", 32'(done_m), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      s_rise = rise_m; s_cs = cslow_m; s_dm = dcnt_m; s_dl = dcnt_l;
      start_word(vecs[i].din);
      check($sformatf("v%0d setup cs_n", i), 32'(cs_m), 32'd0);
      check($sformatf("v%0d setup ready", i), 32'(rdy_m), 32'd0);
      check($sformatf("v%0d first bit msb", i), 32'(r_m), 32'(vecs[i].exp_m[7]));
      check($sformatf("v%0d first bit lsb", i), 32'(r_l), 32'(vecs[i].exp_l[7]));
      wait_done($sformatf("v%0d", i));
      repeat (3) @(posedge clk);
      #1;
      check($sformatf("v%0d msb bits", i), 32'(cap_m), 32'(vecs[i].exp_m));
      check($sformatf("v%0d lsb bits", i), 32'(cap_l), 32'(vecs[i].exp_l));
      check($sformatf("v%0d sclk rises", i), 32'(rise_m - s_rise), 32'd8);
      check($sformatf("v%0d cs_n low cycles", i), 32'(cslow_m - s_cs), 32'd36);
      check($sformatf("v%0d done pulses msb", i), 32'(dcnt_m - s_dm), 32'd1);
      check($sformatf("v%0d done pulses lsb", i), 32'(dcnt_l - s_dl), 32'd1);
`ifdef PISO_STREAM_SDI_EN
      check($sformatf("v%0d sdi data_out", i), 32'(last_sdi), 32'(vecs[i].din));
`endif
    end

    // Back-to-back: valid held high across two words.
    s_cs = cslow_m; s_dm = dcnt_m;
    @(posedge clk); #1;
    data  = 8'hAC;
    valid = 1'b1;
    @(posedge clk); #1;
    data  = 8'h53;
    wait_done("b2b first");
    check("b2b first bits", 32'(cap_m), 32'hAC);
    @(posedge clk); #1;
    check("b2b second accepted", 32'(cs_m), 32'd0);
    valid = 1'b0;
    wait_done("b2b second");
    repeat (2) @(posedge clk);
    #1;
    check("b2b second bits msb", 32'(cap_m), 32'h53);
    check("b2b second bits lsb", 32'(cap_l), 32'hCA);
    check("b2b cs_n gap", 32'(last_gap), 32'd1);
    check("b2b done pulses", 32'(dcnt_m - s_dm), 32'd2);
    check("b2b cs_n low cycles", 32'(cslow_m - s_cs), 32'd72);

    // valid pulsed mid-frame must be ignored.
    s_cs = cslow_m; s_dm = dcnt_m;
    start_word(8'hAC);
    repeat (10) @(posedge clk);
    #1;
    data  = 8'hFF;
    valid = 1'b1;
    check("busy ready low", 32'(rdy_m), 32'd0);
    @(posedge clk); #1;
    valid = 1'b0;
    wait_done("ignore");
    repeat (60) @(posedge clk);
    #1;
    check("ignore bits", 32'(cap_m), 32'hAC);
    check("ignore done pulses", 32'(dcnt_m - s_dm), 32'd1);
    check("ignore cs_n low cycles", 32'(cslow_m - s_cs), 32'd36);
    check("ignore idle cs_n", 32'(cs_m), 32'd1);

    // Reset after the third sclk rise aborts the frame.
    s_rise = rise_m; s_dm = dcnt_m;
    start_word(8'hAC);
    begin
      int n = 0;
      while ((rise_m - s_rise) < 3 && n < 200) begin
        @(negedge clk); #1;
        n++;
      end
      check("abort third rise reached", 32'(rise_m - s_rise), 32'd3);
    end
    rst = 1'b1;
    #1;
    check("abort cs_n", 32'(cs_m), 32'd1);
    check("abort sclk", 32'(sclk_m), 32'd0);
    check("abort r_out", 32'(r_m), 32'd0);
    check("abort ready", 32'(rdy_m), 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    data  = 8'h53;
    valid = 1'b1;
    rst   = 1'b0;
    check("abort no done", 32'(dcnt_m - s_dm), 32'd0);
    @(posedge clk); #1;
    valid = 1'b0;
    check("post-reset accept cs_n", 32'(cs_m), 32'd0);
    wait_done("post-reset");
    repeat (2) @(posedge clk);
    #1;
    check("post-reset bits msb", 32'(cap_m), 32'h53);
    check("post-reset bits lsb", 32'(cap_l), 32'hCA);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/piso_stream.md
PISO_STREAM -- requirements
Module: piso_stream

Interface
REQ-001 SHALL have parameter SIZE, default 8, word width in bits (>= 2).
REQ-002 SHALL have parameter DIV, default 2, sclk half-period in clk_in cycles (>= 1).
REQ-003 SHALL have parameter LSB_FIRST, default 0, bit order (0 = MSB first, 1 = LSB first).
REQ-004 SHALL have port clk_in  input  1  single system clock, rising-edge active.
REQ-005 SHALL have port reset_in  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port data_in  input  SIZE  parallel word to send.
REQ-007 SHALL have port valid_in  input  1  data_in valid request.
REQ-008 SHALL have port ready_out  output  1  block can accept a word.
REQ-009 SHALL have port r_out  output  1  serial data, registered.
REQ-010 SHALL have port sclk_out  output  1  serial clock, idle low.
REQ-011 SHALL have port cs_n_out  output  1  frame select, active-low.
REQ-012 SHALL have port done_out  output  1  one-cycle end-of-frame pulse.

Function
REQ-013 SHALL use FSM states IDLE, SETUP, SHIFT, HOLD; ready_out = 1 only in IDLE.
REQ-014 SHALL accept a word on the rising clk_in edge where valid_in && ready_out; data_in is latched internally and later changes have no effect.
REQ-015 SHALL, on accept, go to SETUP: cs_n_out = 0, r_out = first bit, sclk_out = 0, ready_out = 0.
REQ-016 SHALL, after DIV cycles in SETUP, enter SHIFT and drive SIZE sclk periods, each DIV cycles high then DIV cycles low.
REQ-017 SHALL hold r_out stable while sclk_out is high and advance to the next bit only on sclk_out falling edges.
REQ-018 SHALL, after the SIZE-th falling edge, enter HOLD for DIV cycles with sclk_out = 0 and r_out unchanged.
REQ-019 SHALL, on leaving HOLD, set cs_n_out = 1, pulse done_out for exactly 1 cycle, and enter IDLE.
REQ-020 SHALL keep cs_n_out low for exactly DIV*(2*SIZE+2) cycles per frame (36 for SIZE=8, DIV=2).
REQ-021 SHALL allow accepting a new word in the done_out cycle, giving back-to-back frames with cs_n_out high for exactly 1 cycle.
REQ-022 SHALL ignore valid_in while ready_out = 0, with no queuing.
REQ-023 SHALL use bit counter and divider widths of clog2(SIZE+1) and clog2(DIV+1), with no wrap before the terminal count.

Reset
REQ-024 SHALL, while reset_in = 1, immediately force the following, independent of clk_in: r_out = 0, sclk_out = 0, cs_n_out = 1, done_out = 0, ready_out = 1, FSM = IDLE, counters = 0.
REQ-025 SHALL abort any frame in progress on reset, without a done_out pulse, and SHALL accept new words from the first clk_in edge after reset_in falls.

Configuration
REQ-026 SHALL, with macro PISO_STREAM_SDI_EN defined, add port sdi_in (input, 1) and port data_out (output, SIZE, reset 0).
REQ-027 SHALL, with PISO_STREAM_SDI_EN defined, sample sdi_in on each clk_in cycle where sclk_out rises, shift it in using the same bit order as r_out, and update data_out in the done_out cycle.
REQ-028 SHALL, without PISO_STREAM_SDI_EN, omit sdi_in, data_out and all capture logic; r_out timing is identical in both builds.

Verification
REQ-029 SHALL cover: SIZE=8, DIV=2, data_in=8'hAC, one valid_in pulse -> r_out at the 8 sclk rising edges = 1,0,1,0,1,1,0,0; cs_n_out low for 36 cycles; exactly one done_out pulse.
REQ-030 SHALL cover: LSB_FIRST=1, data_in=8'hAC -> r_out at the sclk rising edges = 0,0,1,1,0,1,0,1.
REQ-031 SHALL cover: valid_in held high with 8'hAC then 8'h53 -> two frames; cs_n_out high for exactly 1 cycle between them; second frame's bits = 0,1,0,1,0,0,1,1.
REQ-032 SHALL cover: valid_in pulsed with 8'hFF during a frame carrying 8'hAC -> ignored; the frame completes unchanged; no second frame.
REQ-033 SHALL cover: reset_in raised after the 3rd sclk rising edge -> cs_n_out = 1, sclk_out = 0, r_out = 0 before the next clk_in edge; no done_out pulse; ready_out = 1.
REQ-034 SHALL cover: PISO_STREAM_SDI_EN defined, r_out looped to sdi_in, DIV=1, data_in=8'hAC -> data_out = 8'hAC in the done_out cycle.
